alu_issue_ctrl: RTL
===================

Name: alu_issue_ctrl

Overview:
- Multi-cycle issue/writeback controller that sits directly upstream of the team's 16-bit ALU (3-bit opcode, ina/inb/inc in; w/zer/neg out).
- Holds a small register file and a flag register, accepts one instruction per handshake, and drives the ALU operands from registered state.
- Captures the ALU result and flags, writes back to the register file, and reports each completion on a result strobe.

Parameters:
- W, 16, datapath width; must match the ALU width.
- NREG, 4, register-file depth; index width is $clog2(NREG).

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  instruction valid
- in_ready  out  1  controller can accept an instruction
- in_opc  in  3  ALU opcode; 3'b111 = load immediate
- in_dst  in  2  destination register index
- in_sa  in  2  source A register index
- in_sb  in  2  source B register index
- in_usec  in  1  1 = drive inc from stored carry flag; 0 = inc=0
- in_imm  in  W  immediate value for opcode 111
- alu_opc  out  3  to ALU opc
- alu_ina  out  W  to ALU ina
- alu_inb  out  W  to ALU inb
- alu_inc  out  1  to ALU inc
- alu_w  in  W  ALU result
- alu_zer  in  1  ALU zero flag
- alu_neg  in  1  ALU negative flag
- res_valid  out  1  one-cycle completion strobe
- res_data  out  W  written-back value
- flg_z  out  1  stored zero flag
- flg_n  out  1  stored negative flag
- flg_c  out  1  stored carry flag
- rd_sel  in  2  debug read index
- rd_data  out  W  combinational read of reg[rd_sel]

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE; all registers, flags, and alu_* outputs are 0.
  - res_valid=0, res_data=0.
  - in_ready=0 while rst_n is low.
- FSM states: IDLE, EXEC, WB.
  - in_ready = rst_n & (state==IDLE).
- IDLE:
  - On in_valid&in_ready, latch opc/dst/usec/imm.
  - Latch alu_ina=reg[sa], alu_inb=reg[sb], alu_opc=opc, alu_inc=usec&flg_c.
  - Then go to EXEC; opc 111 goes directly to WB.
- EXEC: the ALU settles combinationally on the registered operands; go to WB next cycle.
- WB (one cycle), for ALU ops:
  - reg[dst]<=alu_w; flg_z<=alu_zer; flg_n<=alu_neg.
  - flg_c <= bit W of ({1'b0,alu_ina}+alu_inb+alu_inc) for opc 010, bit W of (alu_ina+1) for opc 001, otherwise unchanged.
  - res_valid=1 and res_data=alu_w during this cycle (registered).
  - Go to IDLE.
- WB for opc 111: reg[dst]<=imm; flg_z/flg_n are set from imm (imm==0, imm[W-1]); flg_c is unchanged; res_data=imm.
- Latency: handshake at cycle 0; ALU op writes back at end of cycle 2 (res_valid high in cycle 2); load immediate at end of cycle 1. The next instruction can be accepted in cycle 3 / cycle 2 respectively.
- Hazards:
  - Operands are read at issue, after the previous writeback has completed, so back-to-back dependent instructions see updated values.
  - Flags are likewise final before the next issue.
- dst==sa or dst==sb is legal; the old value is used as the operand.
- rd_data is combinational; a read during WB returns the pre-write value and updates the next cycle.
- in_valid while not ready: no effect; the instruction must be held by the source.
- Inputs other than in_valid are don't-care when in_valid=0.
- Reset mid-EXEC/WB: abort immediately and return to IDLE with reset values; no partial writeback.

Decomposition:
- Shared package alu_pkg:
  - Opcode localparams OP_NEG=000, OP_INC=001, OP_ADD=010, OP_ADDSHR=011, OP_AND=100, OP_OR=101, OP_CAT=110, OP_LDI=111.
  - FSM state typedef {IDLE,EXEC,WB}.
- One natural sub-module: alu_regfile (NREG x W, one write port, two issue read ports, one debug read port, async clear).

Test Plan:
- Reset with rst_n=0 mid-EXEC -> next cycle state IDLE, all regs 0, res_valid=0, in_ready=0 until rst_n=1.
- LDI r1=0x7FFF, LDI r2=0x0001, ADD r3=r1+r2 (usec=0) -> r3=0x8000, flg_n=1, flg_z=0, flg_c=0, res_valid high in cycle 2 after the handshake.
- LDI r0=0xFFFF, LDI r1=0x0001, ADD r2=r0+r1 -> r2=0x0000, flg_z=1, flg_c=1; then ADD r3=r1+r1 with usec=1 -> r3=0x0003, flg_c=0.
- Dependent chain INC r1 (r1=0x00FF) three times back-to-back with in_valid held -> r1=0x0102; in_ready low during EXEC/WB; exactly 3 res_valid pulses.
- CAT r2 from r0=0x12AB, r1=0x34CD -> alu_opc=110, r2=0xABCD, flg_n=1.
- dst==sa: r1=0x0005, NEG r1=-r1 -> r1=0xFFFB, flg_n=1; rd_sel=1 shows 0x0005 during WB and 0xFFFB one cycle later.

Source files
------------

// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
//    Shared definitions for the ALU issue/writeback controller and its
//    register file: the ALU opcode encodings and the controller FSM states.
// ----------------------------------------------------------------------------
package alu_pkg;

   // Opcodes understood by the downstream 16-bit ALU. OP_LDI never reaches
   // the ALU datapath; the controller handles it internally.
   localparam logic [2:0] OP_NEG    = 3'b000;
   localparam logic [2:0] OP_INC    = 3'b001;
   localparam logic [2:0] OP_ADD    = 3'b010;
   localparam logic [2:0] OP_ADDSHR = 3'b011;
   localparam logic [2:0] OP_AND    = 3'b100;
   localparam logic [2:0] OP_OR     = 3'b101;
   localparam logic [2:0] OP_CAT    = 3'b110;
   localparam logic [2:0] OP_LDI    = 3'b111;

   // Issue controller states: waiting for an instruction, letting the ALU
   // settle on registered operands, and committing the result.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      WB   = 2'd2
   } state_e;

endpackage

// File: rtl/alu_regfile.sv
// ----------------------------------------------------------------------------
// alu_regfile
//    NREG x W register file with one synchronous write port, two
//    combinational issue read ports and one combinational debug read port.
//    All entries clear asynchronously while rst_n is low.
//
//    Ports:
//       clk        clock, rising edge
//       rst_n      asynchronous active-low clear
//       we_i       write enable
//       waddr_i    write index
//       wdata_i    write data
//       raddr_a_i  issue read index A  -> rdata_a_o
//       raddr_b_i  issue read index B  -> rdata_b_o
//       raddr_d_i  debug read index    -> rdata_d_o
// ----------------------------------------------------------------------------
module alu_regfile #(
   parameter  int W    = 16,
   parameter  int NREG = 4,
   localparam int IW   = $clog2(NREG)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we_i,
   input  logic [IW-1:0] waddr_i,
   input  logic [W-1:0]  wdata_i,
   input  logic [IW-1:0] raddr_a_i,
   output logic [W-1:0]  rdata_a_o,
   input  logic [IW-1:0] raddr_b_i,
   output logic [W-1:0]  rdata_b_o,
   input  logic [IW-1:0] raddr_d_i,
   output logic [W-1:0]  rdata_d_o
);

   logic [W-1:0] mem_q [NREG];

   // Storage: cleared as a whole on reset, otherwise one entry per cycle
   // is written when the controller commits a result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Reads are purely combinational, so a read in the same cycle as a write
   // returns the old contents.
   assign rdata_a_o = mem_q[raddr_a_i];
   assign rdata_b_o = mem_q[raddr_b_i];
   assign rdata_d_o = mem_q[raddr_d_i];

endmodule

// File: rtl/alu_issue_ctrl.sv
// ----------------------------------------------------------------------------
// alu_issue_ctrl
//    Multi-cycle issue/writeback controller placed in front of the 16-bit ALU.
//    Accepts one instruction per valid/ready handshake, reads operands from
//    the register file into registered ALU inputs, waits one cycle for the
//    ALU to settle, then writes the result and flags back and pulses
//    res_valid. Load-immediate (opcode 111) skips the ALU cycle.
//
//    Ports:
//       clk, rst_n              clock (rising) and async active-low reset
//       in_valid / in_ready     instruction handshake
//       in_opc, in_dst,
//       in_sa, in_sb,
//       in_usec, in_imm         instruction fields
//       alu_opc/ina/inb/inc     registered operands driven to the ALU
//       alu_w/zer/neg           ALU result and flags
//       res_valid, res_data     one-cycle completion strobe and value
//       flg_z/flg_n/flg_c       stored flags
//       rd_sel, rd_data         combinational debug register read
// ----------------------------------------------------------------------------
module alu_issue_ctrl
   import alu_pkg::*;
#(
   parameter  int W    = 16,
   parameter  int NREG = 4,
   localparam int IW   = $clog2(NREG)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [2:0]    in_opc,
   input  logic [IW-1:0] in_dst,
   input  logic [IW-1:0] in_sa,
   input  logic [IW-1:0] in_sb,
   input  logic          in_usec,
   input  logic [W-1:0]  in_imm,
   output logic [2:0]    alu_opc,
   output logic [W-1:0]  alu_ina,
   output logic [W-1:0]  alu_inb,
   output logic          alu_inc,
   input  logic [W-1:0]  alu_w,
   input  logic          alu_zer,
   input  logic          alu_neg,
   output logic          res_valid,
   output logic [W-1:0]  res_data,
   output logic          flg_z,
   output logic          flg_n,
   output logic          flg_c,
   input  logic [IW-1:0] rd_sel,
   output logic [W-1:0]  rd_data
);

   state_e        state_q, state_d;
   logic [2:0]    opc_q, opc_d;
   logic [W-1:0]  ina_q, ina_d;
   logic [W-1:0]  inb_q, inb_d;
   logic          inc_q, inc_d;
   logic [IW-1:0] dst_q, dst_d;
   logic [W-1:0]  imm_q, imm_d;
   logic          flgZ_q, flgZ_d;
   logic          flgN_q, flgN_d;
   logic          flgC_q, flgC_d;
   logic          resValid_q, resValid_d;
   logic [W-1:0]  resData_q, resData_d;

   logic          accept;
   logic          rfWe;
   logic [W-1:0]  rfWdata;
   logic [W-1:0]  rdataA;
   logic [W-1:0]  rdataB;
   logic [W:0]    sumAdd;
   logic [W:0]    sumInc;

   alu_regfile #(
      .W    (W),
      .NREG (NREG)
   ) u_regfile (
      .clk       (clk),
      .rst_n     (rst_n),
      .we_i      (rfWe),
      .waddr_i   (dst_q),
      .wdata_i   (rfWdata),
      .raddr_a_i (in_sa),
      .rdata_a_o (rdataA),
      .raddr_b_i (in_sb),
      .rdata_b_o (rdataB),
      .raddr_d_i (rd_sel),
      .rdata_d_o (rd_data)
   );

   // Ready is gated by rst_n so that nothing is accepted while reset is held.
   assign in_ready = rst_n & (state_q == IDLE);
   assign accept   = in_valid & in_ready;

   // The ALU does not report carry, so it is recomputed here from the
   // registered operands, which stay stable through EXEC and WB.
   assign sumAdd = {1'b0, ina_q} + {1'b0, inb_q} + {{W{1'b0}}, inc_q};
   assign sumInc = {1'b0, ina_q} + {{W{1'b0}}, 1'b1};

   // Next-state and datapath control. Operands are captured at issue from
   // the register file, which already holds the previous writeback, so
   // dependent back-to-back instructions need no forwarding. res_valid is
   // registered on entry to WB so that it is high exactly during WB.
   always_comb begin
      state_d    = state_q;
      opc_d      = opc_q;
      ina_d      = ina_q;
      inb_d      = inb_q;
      inc_d      = inc_q;
      dst_d      = dst_q;
      imm_d      = imm_q;
      flgZ_d     = flgZ_q;
      flgN_d     = flgN_q;
      flgC_d     = flgC_q;
      resValid_d = 1'b0;
      resData_d  = resData_q;
      rfWe       = 1'b0;
      rfWdata    = '0;

      case (state_q)
         IDLE: begin
            if (accept) begin
               opc_d = in_opc;
               ina_d = rdataA;
               inb_d = rdataB;
               inc_d = in_usec & flgC_q;
               dst_d = in_dst;
               imm_d = in_imm;
               if (in_opc == OP_LDI) begin
                  state_d    = WB;
                  resValid_d = 1'b1;
                  resData_d  = in_imm;
               end else begin
                  state_d = EXEC;
               end
            end
         end

         EXEC: begin
            state_d    = WB;
            resValid_d = 1'b1;
            resData_d  = alu_w;
         end

         WB: begin
            rfWe    = 1'b1;
            state_d = IDLE;
            if (opc_q == OP_LDI) begin
               rfWdata = imm_q;
               flgZ_d  = (imm_q == '0);
               flgN_d  = imm_q[W-1];
            end else begin
               rfWdata = alu_w;
               flgZ_d  = alu_zer;
               flgN_d  = alu_neg;
               if (opc_q == OP_ADD) begin
                  flgC_d = sumAdd[W];
               end else if (opc_q == OP_INC) begin
                  flgC_d = sumInc[W];
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any instruction in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         opc_q      <= '0;
         ina_q      <= '0;
         inb_q      <= '0;
         inc_q      <= 1'b0;
         dst_q      <= '0;
         imm_q      <= '0;
         flgZ_q     <= 1'b0;
         flgN_q     <= 1'b0;
         flgC_q     <= 1'b0;
         resValid_q <= 1'b0;
         resData_q  <= '0;
      end else begin
         state_q    <= state_d;
         opc_q      <= opc_d;
         ina_q      <= ina_d;
         inb_q      <= inb_d;
         inc_q      <= inc_d;
         dst_q      <= dst_d;
         imm_q      <= imm_d;
         flgZ_q     <= flgZ_d;
         flgN_q     <= flgN_d;
         flgC_q     <= flgC_d;
         resValid_q <= resValid_d;
         resData_q  <= resData_d;
      end
   end

   assign alu_opc   = opc_q;
   assign alu_ina   = ina_q;
   assign alu_inb   = inb_q;
   assign alu_inc   = inc_q;
   assign res_valid = resValid_q;
   assign res_data  = resData_q;
   assign flg_z     = flgZ_q;
   assign flg_n     = flgN_q;
   assign flg_c     = flgC_q;

endmodule
